// File: rtl/register_bank.sv
// Two-read, one-write register file with a per-register busy scoreboard.
// Register 0 is hardwired to zero and can never be reserved. The busy bits
// track registers that have an issued but unfinished producer. BusyCount is a
// registered popcount of those bits.
module register_bank #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int BYPASS = 1,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic [AW-1:0]   Rs1,
    input  logic [AW-1:0]   Rs2,
    output logic [XLEN-1:0] RuRs1,
    output logic [XLEN-1:0] RuRs2,
    output logic            Busy1,
    output logic            Busy2,
    input  logic [AW-1:0]   Rd,
    input  logic            RuWr,
    input  logic [XLEN-1:0] RuDataWr,
    input  logic [AW-1:0]   IssueRd,
    input  logic            IssueEn,
    output logic [AW:0]     BusyCount
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [AW:0]      busyCount_q;
    logic [AW:0]      busyCount_d;

    logic writeValid;
    logic issueValid;
    logic bypass1;
    logic bypass2;

    assign writeValid = RuWr && (Rd != '0);
    assign issueValid = IssueEn && (IssueRd != '0);
    assign bypass1    = (BYPASS != 0) && writeValid && (Rd == Rs1) && !Rst;
    assign bypass2    = (BYPASS != 0) && writeValid && (Rd == Rs2) && !Rst;

    // Combinational read ports; x0 and reset force zero, bypass forwards the in-flight write.
    always_comb begin
        RuRs1 = '0;
        RuRs2 = '0;
        if (!Rst && (Rs1 != '0)) begin
            RuRs1 = bypass1 ? RuDataWr : regs_q[Rs1];
        end
        if (!Rst && (Rs2 != '0)) begin
            RuRs2 = bypass2 ? RuDataWr : regs_q[Rs2];
        end
    end

    // Busy outputs hide a busy bit being cleared by a forwarded write this cycle, unless it is re-reserved.
    always_comb begin
        Busy1 = 1'b0;
        Busy2 = 1'b0;
        if (!Rst && (Rs1 != '0)) begin
            Busy1 = busy_q[Rs1] && !(bypass1 && !(issueValid && (IssueRd == Rs1)));
        end
        if (!Rst && (Rs2 != '0)) begin
            Busy2 = busy_q[Rs2] && !(bypass2 && !(issueValid && (IssueRd == Rs2)));
        end
    end

    // Scoreboard next state: writeback clears, issue sets afterwards so a new producer wins.
    always_comb begin
        busy_d = busy_q;
        if (writeValid) begin
            busy_d[Rd] = 1'b0;
        end
        if (issueValid) begin
            busy_d[IssueRd] = 1'b1;
        end
        busy_d[0] = 1'b0;
        busyCount_d = '0;
        for (int i = 0; i < NREGS; i++) begin
            busyCount_d = busyCount_d + {{AW{1'b0}}, busy_d[i]};
        end
    end

    // Register storage, cleared asynchronously; x0 is never written.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (writeValid) begin
            regs_q[Rd] <= RuDataWr;
        end
    end

    // Busy bits and their registered count, both dropped on reset.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            busy_q      <= '0;
            busyCount_q <= '0;
        end else begin
            busy_q      <= busy_d;
            busyCount_q <= busyCount_d;
        end
    end

    assign BusyCount = busyCount_q;

endmodule
